// File: rtl/rv64g_operand_issue.sv
// Operand issue stage: holds a decoded uop until its registers are unlocked,
// reads operands (with writeback bypass), locks rd and registers the result.
module rv64g_operand_issue #(
  parameter int NR   = 64,
  parameter int DW   = 64,
  parameter int AW   = $clog2(NR),
  parameter int UOPW = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [UOPW-1:0]  in_uop_i,
  input  logic [AW-1:0]    in_rs1_addr_i,
  input  logic [AW-1:0]    in_rs2_addr_i,
  input  logic [AW-1:0]    in_rs3_addr_i,
  input  logic [2:0]       in_rs_used_i,
  input  logic [AW-1:0]    in_rd_addr_i,
  input  logic             in_rd_we_i,
  input  logic [NR-1:0]    locks_i,
  output logic [AW-1:0]    rs1_addr_o,
  output logic [AW-1:0]    rs2_addr_o,
  output logic [AW-1:0]    rs3_addr_o,
  input  logic [DW-1:0]    rs1_data_i,
  input  logic [DW-1:0]    rs2_data_i,
  input  logic [DW-1:0]    rs3_data_i,
  output logic             lock_en_o,
  output logic [AW-1:0]    lock_addr_o,
  input  logic             wb_en_i,
  input  logic [AW-1:0]    wb_addr_i,
  input  logic [DW-1:0]    wb_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [UOPW-1:0]  out_uop_o,
  output logic [DW-1:0]    out_rs1_data_o,
  output logic [DW-1:0]    out_rs2_data_o,
  output logic [DW-1:0]    out_rs3_data_o,
  output logic [AW-1:0]    out_rd_addr_o,
  output logic             out_rd_we_o
);

  logic                      a_valid_q, a_valid_d;
  logic [UOPW-1:0]           a_uop_q, a_uop_d;
  logic [2:0][AW-1:0]        a_rs_q, a_rs_d;
  logic [2:0]                a_used_q, a_used_d;
  logic [AW-1:0]             a_rd_q, a_rd_d;
  logic                      a_rd_we_q, a_rd_we_d;

  logic                      b_valid_q, b_valid_d;
  logic [UOPW-1:0]           b_uop_q, b_uop_d;
  logic [2:0][DW-1:0]        b_op_q, b_op_d;
  logic [AW-1:0]             b_rd_q, b_rd_d;
  logic                      b_rd_we_q, b_rd_we_d;

  logic [2:0][DW-1:0]        rs_data;
  logic [2:0]                src_blk;
  logic                      dst_blk;
  logic                      a_fire;
  logic                      in_fire;

  function automatic logic [DW-1:0] pick_operand(
    input logic          used,
    input logic [AW-1:0] addr,
    input logic [DW-1:0] rf_data,
    input logic          wb_en,
    input logic [AW-1:0] wb_addr,
    input logic [DW-1:0] wb_data
  );
    if (!used || addr == '0)
      return '0;
    else if (wb_en && wb_addr == addr)
      return wb_data;
    else
      return rf_data;
  endfunction

  assign rs_data = {rs3_data_i, rs2_data_i, rs1_data_i};

  // Hazard evaluation on the held uop; a writeback to a locked register clears it
  always_comb begin
    for (int n = 0; n < 3; n++) begin
      src_blk[n] = a_used_q[n] && (a_rs_q[n] != '0) && locks_i[a_rs_q[n]] &&
                   !(wb_en_i && wb_addr_i == a_rs_q[n]);
    end
    dst_blk = a_rd_we_q && (a_rd_q != '0) && locks_i[a_rd_q] &&
              !(wb_en_i && wb_addr_i == a_rd_q);
  end

  assign a_fire      = a_valid_q && !(|src_blk) && !dst_blk && (!b_valid_q || out_ready_i);
  assign in_ready_o  = !a_valid_q || a_fire;
  assign in_fire     = in_valid_i && in_ready_o;
  assign lock_en_o   = a_fire && a_rd_we_q && (a_rd_q != '0) && !rst_i;
  assign lock_addr_o = a_rd_q;

  assign rs1_addr_o = a_valid_q ? a_rs_q[0] : '0;
  assign rs2_addr_o = a_valid_q ? a_rs_q[1] : '0;
  assign rs3_addr_o = a_valid_q ? a_rs_q[2] : '0;

  always_comb begin
    a_valid_d = a_valid_q;
    a_uop_d   = a_uop_q;
    a_rs_d    = a_rs_q;
    a_used_d  = a_used_q;
    a_rd_d    = a_rd_q;
    a_rd_we_d = a_rd_we_q;
    if (in_fire) begin
      a_valid_d = 1'b1;
      a_uop_d   = in_uop_i;
      a_rs_d    = {in_rs3_addr_i, in_rs2_addr_i, in_rs1_addr_i};
      a_used_d  = in_rs_used_i;
      a_rd_d    = in_rd_addr_i;
      a_rd_we_d = in_rd_we_i;
    end else if (a_fire) begin
      a_valid_d = 1'b0;
    end
  end

  // Output register: loads on issue, drains on handshake, holds under backpressure
  always_comb begin
    b_valid_d = b_valid_q;
    b_uop_d   = b_uop_q;
    b_op_d    = b_op_q;
    b_rd_d    = b_rd_q;
    b_rd_we_d = b_rd_we_q;
    if (a_fire) begin
      b_valid_d = 1'b1;
      b_uop_d   = a_uop_q;
      b_rd_d    = a_rd_q;
      b_rd_we_d = a_rd_we_q;
      for (int n = 0; n < 3; n++) begin
        b_op_d[n] = pick_operand(a_used_q[n], a_rs_q[n], rs_data[n],
                                 wb_en_i, wb_addr_i, wb_data_i);
      end
    end else if (b_valid_q && out_ready_i) begin
      b_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      a_valid_q <= 1'b0;
      b_valid_q <= 1'b0;
      b_uop_q   <= '0;
      b_op_q    <= '0;
      b_rd_q    <= '0;
      b_rd_we_q <= 1'b0;
    end else begin
      a_valid_q <= a_valid_d;
      b_valid_q <= b_valid_d;
      b_uop_q   <= b_uop_d;
      b_op_q    <= b_op_d;
      b_rd_q    <= b_rd_d;
      b_rd_we_q <= b_rd_we_d;
    end
  end

  // Hold-register payload is qualified by a_valid_q and needs no reset
  always_ff @(posedge clk_i) begin
    a_uop_q   <= a_uop_d;
    a_rs_q    <= a_rs_d;
    a_used_q  <= a_used_d;
    a_rd_q    <= a_rd_d;
    a_rd_we_q <= a_rd_we_d;
  end

  assign out_valid_o    = b_valid_q;
  assign out_uop_o      = b_uop_q;
  assign out_rs1_data_o = b_op_q[0];
  assign out_rs2_data_o = b_op_q[1];
  assign out_rs3_data_o = b_op_q[2];
  assign out_rd_addr_o  = b_rd_q;
  assign out_rd_we_o    = b_rd_we_q;

endmodule

// File: tb/tb_rv64g_operand_issue.sv
// Bench for rv64g_operand_issue: scenario tasks plus a scoreboard on the
// execute-side handshake; register file read data is a function of address.
module tb_rv64g_operand_issue;

  localparam int NR = 64, DW = 64, AW = 6, UOPW = 32;

  typedef struct packed {
    logic [UOPW-1:0] uop;
    logic [DW-1:0]   op1;
    logic [DW-1:0]   op2;
    logic [DW-1:0]   op3;
    logic [AW-1:0]   rd;
    logic            we;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [UOPW-1:0] in_uop = '0;
  logic [AW-1:0]   in_rs1 = '0, in_rs2 = '0, in_rs3 = '0, in_rd = '0;
  logic [2:0]      in_used = '0;
  logic            in_we = 1'b0;
  logic [NR-1:0]   locks = '0;
  logic [AW-1:0]   rs1_addr, rs2_addr, rs3_addr;
  logic [DW-1:0]   rs1_data, rs2_data, rs3_data;
  logic            lock_en;
  logic [AW-1:0]   lock_addr;
  logic            wb_en = 1'b0;
  logic [AW-1:0]   wb_addr = '0;
  logic [DW-1:0]   wb_data = '0;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [UOPW-1:0] out_uop;
  logic [DW-1:0]   out_op1, out_op2, out_op3;
  logic [AW-1:0]   out_rd;
  logic            out_we;

  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] rfv(input logic [7:0] tag, input logic [AW-1:0] a);
    return {tag, 50'b0, a};
  endfunction

  assign rs1_data = rfv(8'h11, rs1_addr);
  assign rs2_data = rfv(8'h22, rs2_addr);
  assign rs3_data = rfv(8'h33, rs3_addr);

  rv64g_operand_issue #(.NR(NR), .DW(DW), .AW(AW), .UOPW(UOPW)) dut (
    .clk_i(clk), .rst_i(rst),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_uop_i(in_uop),
    .in_rs1_addr_i(in_rs1), .in_rs2_addr_i(in_rs2), .in_rs3_addr_i(in_rs3),
    .in_rs_used_i(in_used), .in_rd_addr_i(in_rd), .in_rd_we_i(in_we),
    .locks_i(locks),
    .rs1_addr_o(rs1_addr), .rs2_addr_o(rs2_addr), .rs3_addr_o(rs3_addr),
    .rs1_data_i(rs1_data), .rs2_data_i(rs2_data), .rs3_data_i(rs3_data),
    .lock_en_o(lock_en), .lock_addr_o(lock_addr),
    .wb_en_i(wb_en), .wb_addr_i(wb_addr), .wb_data_i(wb_data),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_uop_o(out_uop),
    .out_rs1_data_o(out_op1), .out_rs2_data_o(out_op2), .out_rs3_data_o(out_op3),
    .out_rd_addr_o(out_rd), .out_rd_we_o(out_we)
  );

  // Drive one uop and push its expected issue result
  task automatic drive_uop(input logic [UOPW-1:0] uop, input logic [AW-1:0] r1,
                           input logic [AW-1:0] r2, input logic [AW-1:0] r3,
                           input logic [2:0] used, input logic [AW-1:0] rd,
                           input logic we, input logic [DW-1:0] op2_override,
                           input logic use_override);
    exp_t e;
    in_valid = 1'b1; in_uop = uop; in_rs1 = r1; in_rs2 = r2; in_rs3 = r3;
    in_used = used; in_rd = rd; in_we = we;
    e.uop = uop; e.rd = rd; e.we = we;
    e.op1 = (used[0] && r1 != 0) ? rfv(8'h11, r1) : '0;
    e.op2 = (used[1] && r2 != 0) ? rfv(8'h22, r2) : '0;
    e.op3 = (used[2] && r3 != 0) ? rfv(8'h33, r3) : '0;
    if (use_override) e.op2 = op2_override;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_underflow got uop=%h with nothing expected", out_uop);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (out_uop !== e.uop || out_rd !== e.rd || out_we !== e.we) begin
          errors++;
          $display("FAIL sb_uop got uop=%h rd=%0d we=%0b exp uop=%h rd=%0d we=%0b",
                   out_uop, out_rd, out_we, e.uop, e.rd, e.we);
        end
        checks++;
        if (out_op1 !== e.op1 || out_op2 !== e.op2 || out_op3 !== e.op3) begin
          errors++;
          $display("FAIL sb_ops uop=%h got %h %h %h exp %h %h %h",
                   e.uop, out_op1, out_op2, out_op3, e.op1, e.op2, e.op3);
        end
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) step();
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
    checks++; if (lock_en !== 1'b0) begin errors++; $display("FAIL reset_lock_en got=%0b exp=0", lock_en); end
    checks++; if (out_uop !== '0 || out_op1 !== '0 || out_rd !== '0) begin
      errors++; $display("FAIL reset_out_data got uop=%h op1=%h rd=%0d exp zeros", out_uop, out_op1, out_rd); end
    checks++; if (rs1_addr !== '0) begin errors++; $display("FAIL reset_rs1_addr got=%0d exp=0", rs1_addr); end
    step();
    rst = 1'b0;
  endtask

  task automatic test_stream();
    out_ready = 1'b1; locks = '0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (i < 3) drive_uop(32'h100 + i, 0, 0, 0, 3'b111, AW'(i + 1), 1'b1, '0, 1'b0);
      else in_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (lock_en !== (i >= 1 && i <= 3)) begin
        errors++; $display("FAIL stream_lock_en cyc=%0d got=%0b exp=%0b", i, lock_en, (i >= 1 && i <= 3)); end
      if (i >= 1 && i <= 3) begin
        checks++;
        if (lock_addr !== AW'(i)) begin errors++; $display("FAIL stream_lock_addr cyc=%0d got=%0d exp=%0d", i, lock_addr, i); end
      end
      checks++;
      if (out_valid !== (i >= 2 && i <= 4)) begin
        errors++; $display("FAIL stream_out_valid cyc=%0d got=%0b exp=%0b", i, out_valid, (i >= 2 && i <= 4)); end
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_in_ready cyc=%0d got=%0b exp=1", i, in_ready); end
    end
  endtask

  task automatic test_src_hazard();
    locks = '0; locks[5] = 1'b1;
    step(); drive_uop(32'h200, 5, 0, 0, 3'b001, 6, 1'b1, '0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      step(); in_valid = 1'b0;
      @(negedge clk);
      checks++; if (lock_en !== 1'b0) begin errors++; $display("FAIL src_stall_lock_en got=%0b exp=0", lock_en); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL src_stall_in_ready got=%0b exp=0", in_ready); end
      checks++; if (rs1_addr !== 6'd5) begin errors++; $display("FAIL src_rs1_addr got=%0d exp=5", rs1_addr); end
    end
    step(); locks[5] = 1'b0;
    @(negedge clk);
    checks++; if (lock_en !== 1'b1 || lock_addr !== 6'd6) begin
      errors++; $display("FAIL src_release_lock got en=%0b addr=%0d exp en=1 addr=6", lock_en, lock_addr); end
    step(); @(negedge clk);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL src_out_valid got=%0b exp=1", out_valid); end
    step();
  endtask

  task automatic test_bypass();
    locks = '0; locks[5] = 1'b1;
    step(); drive_uop(32'h300, 0, 5, 0, 3'b010, 8, 1'b1, 64'hDEAD_BEEF, 1'b1);
    step(); in_valid = 1'b0; wb_en = 1'b1; wb_addr = 5; wb_data = 64'hDEAD_BEEF;
    @(negedge clk);
    checks++; if (lock_en !== 1'b1 || lock_addr !== 6'd8) begin
      errors++; $display("FAIL bypass_issue got en=%0b addr=%0d exp en=1 addr=8", lock_en, lock_addr); end
    step(); wb_en = 1'b0; locks = '0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bypass_out_valid got=%0b exp=1", out_valid); end
    step();
  endtask

  task automatic test_waw();
    locks = '0; locks[7] = 1'b1;
    step(); drive_uop(32'h400, 3, 0, 0, 3'b000, 7, 1'b1, '0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      step(); in_valid = 1'b0;
      @(negedge clk);
      checks++; if (lock_en !== 1'b0 || in_ready !== 1'b0) begin
        errors++; $display("FAIL waw_stall got lock_en=%0b in_ready=%0b exp 0 0", lock_en, in_ready); end
    end
    step(); wb_en = 1'b1; wb_addr = 7; wb_data = 64'h123;
    @(negedge clk);
    checks++; if (lock_en !== 1'b1 || lock_addr !== 6'd7) begin
      errors++; $display("FAIL waw_issue got en=%0b addr=%0d exp en=1 addr=7", lock_en, lock_addr); end
    step(); wb_en = 1'b0; locks = '0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL waw_out_valid got=%0b exp=1", out_valid); end
    step();
  endtask

  task automatic test_backpressure();
    locks = '0; out_ready = 1'b0;
    step(); drive_uop(32'h500, 2, 0, 0, 3'b001, 9, 1'b1, '0, 1'b0);
    step(); drive_uop(32'h501, 0, 4, 0, 3'b010, 10, 1'b1, '0, 1'b0);
    @(negedge clk);
    checks++; if (lock_en !== 1'b1 || lock_addr !== 6'd9) begin
      errors++; $display("FAIL bp_first_lock got en=%0b addr=%0d exp en=1 addr=9", lock_en, lock_addr); end
    for (int i = 0; i < 2; i++) begin
      step(); in_valid = 1'b0;
      @(negedge clk);
      checks++; if (out_valid !== 1'b1 || lock_en !== 1'b0 || in_ready !== 1'b0) begin
        errors++; $display("FAIL bp_hold got out_valid=%0b lock_en=%0b in_ready=%0b exp 1 0 0", out_valid, lock_en, in_ready); end
      checks++; if (out_uop !== 32'h500 || out_op1 !== rfv(8'h11, 2)) begin
        errors++; $display("FAIL bp_stable got uop=%h op1=%h exp uop=500 op1=%h", out_uop, out_op1, rfv(8'h11, 2)); end
    end
    step(); out_ready = 1'b1;
    @(negedge clk);
    checks++; if (lock_en !== 1'b1 || lock_addr !== 6'd10) begin
      errors++; $display("FAIL bp_release_lock got en=%0b addr=%0d exp en=1 addr=10", lock_en, lock_addr); end
    step(); @(negedge clk);
    checks++; if (out_valid !== 1'b1 || out_uop !== 32'h501) begin
      errors++; $display("FAIL bp_second got valid=%0b uop=%h exp 1 501", out_valid, out_uop); end
    step(); @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain got=%0b exp=0", out_valid); end
  endtask

  task automatic test_reset_mid();
    locks = '0; out_ready = 1'b0;
    step(); drive_uop(32'h600, 2, 0, 0, 3'b001, 11, 1'b1, '0, 1'b0);
    step(); drive_uop(32'h601, 0, 0, 0, 3'b000, 12, 1'b1, '0, 1'b0);
    step(); in_valid = 1'b0; rst = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    checks++; if (lock_en !== 1'b0) begin errors++; $display("FAIL rstmid_lock_en got=%0b exp=0", lock_en); end
    step(); rst = 1'b0;
    sb.delete();
    @(negedge clk);
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || lock_en !== 1'b0) begin
      errors++; $display("FAIL rstmid_state got out_valid=%0b in_ready=%0b lock_en=%0b exp 0 1 0", out_valid, in_ready, lock_en); end
    checks++; if (out_uop !== '0 || out_op1 !== '0) begin
      errors++; $display("FAIL rstmid_data got uop=%h op1=%h exp 0 0", out_uop, out_op1); end
    step(); @(negedge clk);
    checks++; if (out_valid !== 1'b0 || lock_en !== 1'b0) begin
      errors++; $display("FAIL rstmid_after got out_valid=%0b lock_en=%0b exp 0 0", out_valid, lock_en); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_src_hazard();
    test_bypass();
    test_waw();
    test_backpressure();
    test_reset_mid();
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL sb_leftover got=%0d exp=0", sb.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
